// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: master sequencer for the RTC multiplexed address/data bus.
// One request = address phase, hold gap, data phase, hold gap, done pulse.
// Every pin (strobes, bus enable, bus data) comes straight from a register.
//
// state | meaning
// IDLE  | strobes high, bus released, waiting for start
// ADDR  | CS/AD/WR low, captured address driven (T_PULSE cycles)
// GAP1  | strobes high, address still driven for hold (T_GAP cycles)
// DATA  | CS low, AD high, WR low (write) or RD low (read) (T_PULSE cycles)
// GAP2  | strobes high, write data held or bus released on read (T_GAP cycles)
// DONE  | strobes high, bus released, done pulse (1 cycle)

module rtc_bus_ctrl #(
  parameter int T_PULSE = 4,
  parameter int T_GAP   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  inout  wire  [7:0] datRTC,
  output logic       CS,
  output logic       AD,
  output logic       RD,
  output logic       WR
);

  localparam logic [3:0] PULSE_LD = 4'(T_PULSE - 1);
  localparam logic [3:0] GAP_LD   = 4'(T_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2, S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       cnt_zero;
  logic       rw_q, rw_nxt;
  logic [7:0] addr_q, addr_nxt;
  logic [7:0] wdata_q, wdata_nxt;

  logic       cs_d, ad_d, rd_d, wr_d, oe_d, busy_d, done_d;
  logic [7:0] dout_d;
  logic       oe_q;
  logic [7:0] dout_q;

  assign cnt_zero = (cnt == 4'd0);

  // State, phase timer, request capture and registered pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      CS      <= 1'b1;
      AD      <= 1'b1;
      RD      <= 1'b1;
      WR      <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rw_q    <= rw_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      CS      <= cs_d;
      AD      <= ad_d;
      RD      <= rd_d;
      WR      <= wr_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      busy    <= busy_d;
      done    <= done_d;
      // RD is still low on this edge, so the RTC is still driving the bus
      if (state == S_DATA && cnt_zero && rw_q) begin
        rdata <= datRTC;
      end
    end
  end

  // Next state, timer reload on phase entry, capture of the request in IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rw_nxt    = rw_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ADDR;
          cnt_nxt   = PULSE_LD;
          rw_nxt    = rw;
          addr_nxt  = addr;
          wdata_nxt = wdata;
        end
      end
      S_ADDR: begin
        if (cnt_zero) begin
          state_nxt = S_GAP1;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_GAP1: begin
        if (cnt_zero) begin
          state_nxt = S_DATA;
          cnt_nxt   = PULSE_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DATA: begin
        if (cnt_zero) begin
          state_nxt = S_GAP2;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_GAP2: begin
        if (cnt_zero) begin
          state_nxt = S_DONE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pin values for the upcoming state, so the registers present them in it
  always_comb begin
    cs_d   = 1'b1;
    ad_d   = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    oe_d   = 1'b0;
    dout_d = dout_q;
    busy_d = (state_nxt != S_IDLE);
    done_d = (state_nxt == S_DONE);
    case (state_nxt)
      S_ADDR: begin
        cs_d   = 1'b0;
        ad_d   = 1'b0;
        wr_d   = 1'b0;
        oe_d   = 1'b1;
        dout_d = addr_nxt;
      end
      S_GAP1: begin
        oe_d   = 1'b1;
        dout_d = addr_nxt;
      end
      S_DATA: begin
        cs_d   = 1'b0;
        rd_d   = ~rw_nxt;
        wr_d   = rw_nxt;
        oe_d   = ~rw_nxt;
        dout_d = wdata_nxt;
      end
      S_GAP2: begin
        oe_d   = ~rw_nxt;
        dout_d = wdata_nxt;
      end
      default: begin
        oe_d = 1'b0;
      end
    endcase
  end

  assign datRTC = oe_q ? dout_q : 8'hzz;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: directed bench for rtc_bus_ctrl with a small RTC model on
// the default instance and fixed-reply RTCs on two timing-sweep instances.

module tb_rtc_bus_ctrl;

  logic       clk;
  logic       reset;
  logic       start, start_f, start_s;
  logic       rw;
  logic [7:0] addr, wdata;

  logic [7:0] rdata, rdata_f, rdata_s;
  logic       busy, busy_f, busy_s;
  logic       done, done_f, done_s;
  logic       cs, ad, rd, wr;
  logic       cs_f, ad_f, rd_f, wr_f;
  logic       cs_s, ad_s, rd_s, wr_s;
  wire  [7:0] bus, bus_f, bus_s;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  rtc_bus_ctrl #(.T_PULSE(4), .T_GAP(2)) u_dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .datRTC(bus),
    .CS(cs), .AD(ad), .RD(rd), .WR(wr));

  rtc_bus_ctrl #(.T_PULSE(1), .T_GAP(1)) u_fast (
    .clk(clk), .reset(reset), .start(start_f), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata_f), .busy(busy_f), .done(done_f), .datRTC(bus_f),
    .CS(cs_f), .AD(ad_f), .RD(rd_f), .WR(wr_f));

  rtc_bus_ctrl #(.T_PULSE(15), .T_GAP(15)) u_slow (
    .clk(clk), .reset(reset), .start(start_s), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata_s), .busy(busy_s), .done(done_s), .datRTC(bus_s),
    .CS(cs_s), .AD(ad_s), .RD(rd_s), .WR(wr_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RTC model: latch address in the address phase, store on write strobe,
  // drive the addressed byte while RD is low.
  logic [7:0] mem [256];
  logic [7:0] lat;
  always @(posedge clk) begin
    if (!cs && !ad) lat = bus;
    if (!cs && ad && !wr) mem[lat] = bus;
  end
  assign bus   = (!cs && !rd) ? mem[lat] : 8'hzz;
  assign bus_f = !rd_f ? 8'hA5 : 8'hzz;
  assign bus_s = !rd_s ? 8'hA5 : 8'hzz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic rw_i, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    rw = rw_i; addr = a; wdata = d; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done !== 1'b1 && k < 80);
    check(tag, 32'(k), 32'(exp_cyc));
  endtask

  // Per-cycle invariants: no drive while RD low, AD moves only next to CS high
  logic ad_p, cs_p, ad_fp, cs_fp, ad_sp, cs_sp;
  always @(negedge clk) begin
    if (reset) begin
      if (!rd)   check("bus_safety",      32'(u_dut.oe_q),  32'd0);
      if (!rd_f) check("bus_safety_fast", 32'(u_fast.oe_q), 32'd0);
      if (!rd_s) check("bus_safety_slow", 32'(u_slow.oe_q), 32'd0);
      if (ad !== ad_p)     check("ad_order",      32'(cs_p | cs),     32'd1);
      if (ad_f !== ad_fp)  check("ad_order_fast", 32'(cs_fp | cs_f), 32'd1);
      if (ad_s !== ad_sp)  check("ad_order_slow", 32'(cs_sp | cs_s), 32'd1);
    end
    ad_p = ad;   cs_p = cs;
    ad_fp = ad_f; cs_fp = cs_f;
    ad_sp = ad_s; cs_sp = cs_s;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h22] = 8'h37;
    mem[8'h23] = 8'h5A;
    start = 0; start_f = 0; start_s = 0;
    rw = 0; addr = 8'h00; wdata = 8'h00;
    reset = 1'b1;
    #2 reset = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_pins",  {cs, ad, rd, wr}, 4'hF);
    check("rst_oe",    32'(u_dut.oe_q), 32'd0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_busy",  {busy, done}, 2'b00);
    check("rst_sweep", {cs_f, ad_f, rd_f, wr_f, cs_s, ad_s, rd_s, wr_s}, 8'hFF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: write 0x15 to 0x21
    launch(1'b0, 8'h21, 8'h15);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k <= 4)            check("t1_addr_phase", {cs, ad, wr, rd, bus}, {4'b0001, 8'h21});
      if (k >= 7 && k <= 10) check("t1_data_phase", {cs, ad, wr, rd, bus}, {4'b0101, 8'h15});
      if (k >= 1 && k <= 13) check("t1_busy", 32'(busy), 32'd1);
      check("t1_done", 32'(done), 32'(k == 13));
    end
    check("t1_rtc_mem", mem[8'h21], 8'h15);

    // 2: read 0x22, RTC returns 0x37
    launch(1'b1, 8'h22, 8'h00);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k >= 7 && k <= 10) begin
        check("t2_strobes", {cs, ad, wr, rd}, 4'b0110);
        check("t2_bus", bus, 8'h37);
      end
      if (k >= 7 && k <= 12) check("t2_no_drive", 32'(u_dut.oe_q), 32'd0);
      check("t2_rdata", rdata, (k >= 11) ? 8'h37 : 8'h00);
      check("t2_done", 32'(done), 32'(k == 13));
    end

    // 3: start pulses inside a transaction are ignored; held start after DONE
    launch(1'b0, 8'h40, 8'h66);
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      if (k == 3)  start = 1'b1;
      if (k == 4)  start = 1'b0;
      if (k == 13) begin start = 1'b1; addr = 8'h41; end
      if (k == 14) check("t3_idle_gap", {busy, cs}, 2'b01);
      if (k == 15) begin
        start = 1'b0;
        check("t3_second_addr", {cs, ad, wr, busy, bus}, {4'b0001, 8'h41});
      end
      check("t3_done", 32'(done), 32'(k == 13 || k == 27));
    end
    check("t3_mem_first",  mem[8'h40], 8'h66);
    check("t3_mem_second", mem[8'h41], 8'h66);

    // 4: asynchronous reset in the middle of a read data phase
    launch(1'b1, 8'h22, 8'h00);
    for (int k = 1; k <= 8; k++) @(negedge clk);
    check("t4_pre_rd", {cs, rd}, 2'b00);
    #2 reset = 1'b0;
    #1;
    check("t4_async_pins", {cs, ad, rd, wr}, 4'hF);
    check("t4_async_oe",   32'(u_dut.oe_q), 32'd0);
    check("t4_async_busy", {busy, done}, 2'b00);
    check("t4_rdata",      rdata, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_no_done", {done, busy}, 2'b00);
    end
    reset = 1'b1;
    launch(1'b0, 8'h50, 8'hA3);
    wait_done("t4_write_latency", 13);
    check("t4_mem", mem[8'h50], 8'hA3);
    check("t4_rdata_after", rdata, 8'h00);

    // 5: timing sweep, read 0x31 returning 0xA5
    @(negedge clk);
    rw = 1'b1; addr = 8'h31; start_f = 1'b1; start_s = 1'b1;
    @(posedge clk);
    #1 begin start_f = 1'b0; start_s = 1'b0; end
    for (int k = 1; k <= 62; k++) begin
      @(negedge clk);
      check("t5_fast_done", 32'(done_f), 32'(k == 5));
      check("t5_slow_done", 32'(done_s), 32'(k == 61));
    end
    check("t5_fast_rdata", rdata_f, 8'hA5);
    check("t5_slow_rdata", rdata_s, 8'hA5);

    // 6: a write does not disturb rdata
    launch(1'b1, 8'h23, 8'h00);
    wait_done("t6_read_latency", 13);
    check("t6_rdata_read", rdata, 8'h5A);
    @(negedge clk);
    launch(1'b0, 8'h24, 8'hFF);
    wait_done("t6_write_latency", 13);
    @(negedge clk);
    check("t6_rdata_kept", rdata, 8'h5A);
    check("t6_mem", mem[8'h24], 8'hFF);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
